neuron_mac: RTL and testbench

Serial multiply-accumulate neuron stage that sits directly upstream of the activation unit. It accepts NIN input/weight pairs one per handshake, accumulates their signed products at full width, adds a bias, and rescales and saturates the result to PREC bits. The result is a registered pre-activation value with a valid/ready output, ready to feed the activation stage.

---
 rtl/neuron_mac.sv | 169 ++++++++++++++++
 tb/tb_neuron_mac.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: serial multiply-accumulate neuron stage feeding the activation unit.
// Accepts NIN (input, weight) pairs one per handshake and sums their signed
// products at full width. It then adds a bias that is captured with the first
// pair. The sum is rescaled by FRAC (FXP only) and saturated to PREC bits.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid / in_ready  input pair handshake (in_ready depends on state only)
//   in_data, in_weight   signed operands, PREC bits
//   bias                 signed bias, sampled on pair 0 of each evaluation
//   out_valid/out_ready  result handshake
//   out_data             registered, saturated pre-activation value
//   out_ovf              result was clamped (qualified by out_valid)

package neuron_mac_pkg;
    typedef enum logic [1:0] {
        DT_BOOL = 2'd0,
        DT_INT  = 2'd1,
        DT_FXP  = 2'd2,
        DT_FP   = 2'd3
    } dtype_e;

    typedef struct packed {
        dtype_e     dtype;
        logic [7:0] prec;
    } dconf_t;
endpackage

`ifndef DEF_DCONF
`define DEF_DCONF '{dtype: neuron_mac_pkg::DT_INT, prec: 8'd8}
`endif

module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter dconf_t CONF = `DEF_DCONF,
    parameter int     PREC = int'(CONF.prec),
    parameter int     NIN  = 4,
    parameter int     FRAC = PREC / 2,
    parameter int     ACCW = 2 * PREC + $clog2(NIN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PREC-1:0] in_data,
    input  logic [PREC-1:0] in_weight,
    input  logic [PREC-1:0] bias,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PREC-1:0] out_data,
    output logic            out_ovf
);
    // Integer mode uses no fractional scaling.
    localparam int SH = (CONF.dtype == DT_FXP) ? FRAC : 0;
    localparam int PW = 2 * PREC;
    localparam int CW = (NIN > 1) ? $clog2(NIN) : 1;
    // One spare bit so that adding the shifted bias can never wrap.
    localparam int SW = ACCW + 1;
    localparam logic [CW-1:0] LAST = CW'(NIN - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (PREC - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    if (!((CONF.dtype == DT_INT) || (CONF.dtype == DT_FXP))) begin : g_bad_dtype
        $error("neuron_mac: only INT and FXP datapaths are supported");
    end
    if (NIN < 1) begin : g_bad_nin
        $error("neuron_mac: NIN must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_FIN = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t                   state;
    logic [CW-1:0]            count;
    logic signed [ACCW-1:0]   acc;
    logic signed [PREC-1:0]   bias_r;

    logic signed [PW-1:0]     prod;
    logic signed [ACCW-1:0]   prod_ext;
    logic signed [SW-1:0]     sum;
    logic signed [SW-1:0]     res;
    logic [PREC-1:0]          sat_data;
    logic                     sat_ovf;

    // Full-width signed product, sign-extended to the accumulator width.
    assign prod     = PW'($signed(in_data)) * PW'($signed(in_weight));
    assign prod_ext = ACCW'(prod);

    // Bias is aligned to the product's binary point before the rescale; the
    // arithmetic right shift gives floor rounding.
    assign sum = SW'(acc) + (SW'(bias_r) <<< SH);
    assign res = sum >>> SH;

    // Clamp the rescaled sum to the PREC-bit signed range and flag clamping.
    always_comb begin
        sat_data = res[PREC-1:0];
        sat_ovf  = 1'b0;
        if (res > SAT_MAX) begin
            sat_data = SAT_MAX[PREC-1:0];
            sat_ovf  = 1'b1;
        end else if (res < SAT_MIN) begin
            sat_data = SAT_MIN[PREC-1:0];
            sat_ovf  = 1'b1;
        end else begin
            sat_data = res[PREC-1:0];
            sat_ovf  = 1'b0;
        end
    end

    // Control FSM with accumulator, bias capture and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ACC;
            count     <= '0;
            acc       <= '0;
            bias_r    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    // in_ready is high in this state, so in_valid alone means transfer.
                    if (in_valid) begin
                        if (count == '0) begin
                            acc    <= prod_ext;
                            bias_r <= $signed(bias);
                        end else begin
                            acc <= acc + prod_ext;
                        end
                        if (count == LAST) begin
                            state    <= ST_FIN;
                            in_ready <= 1'b0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                ST_FIN: begin
                    out_data  <= sat_data;
                    out_ovf   <= sat_ovf;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        count     <= '0;
                        acc       <= '0;
                        in_ready  <= 1'b1;
                        state     <= ST_ACC;
                    end
                end
                default: begin
                    state     <= ST_ACC;
                    count     <= '0;
                    acc       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: an INT and an FXP instance (NIN=4) share one
// input stream, and a third INT instance exercises NIN=1.
module tb_neuron_mac;
    import neuron_mac_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    localparam dconf_t CONF_INT = '{dtype: DT_INT, prec: 8'd8};
    localparam dconf_t CONF_FXP = '{dtype: DT_FXP, prec: 8'd8};

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, out_ready;
    logic [7:0] in_data, in_weight, bias;
    logic       in_ready_i, out_valid_i, out_ovf_i;
    logic [7:0] out_data_i;
    logic       in_ready_f, out_valid_f, out_ovf_f;
    logic [7:0] out_data_f;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_ovf1;
    logic [7:0] in_data1, in_weight1, bias1, out_data1;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t exp_q[3][$];
    int   nin_of[3]   = '{4, 4, 1};
    logic prev_ov[3], prev_ordy[3], prev_oo[3];
    logic [7:0] prev_od[3];
    int   xcnt[3], rise_exp[3];
    logic or_stall = 1'b0;
    logic or_block = 1'b0;
    int   low_cnt  = 0;

    neuron_mac #(.CONF(CONF_INT), .NIN(4)) u_int (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_i),
        .in_data(in_data), .in_weight(in_weight), .bias(bias),
        .out_valid(out_valid_i), .out_ready(out_ready), .out_data(out_data_i), .out_ovf(out_ovf_i)
    );

    neuron_mac #(.CONF(CONF_FXP), .NIN(4)) u_fxp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_f),
        .in_data(in_data), .in_weight(in_weight), .bias(bias),
        .out_valid(out_valid_f), .out_ready(out_ready), .out_data(out_data_f), .out_ovf(out_ovf_f)
    );

    neuron_mac #(.CONF(CONF_INT), .NIN(1)) u_n1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_weight(in_weight1), .bias(bias1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_ovf(out_ovf1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: exact sum in 64 bits, floor shift, clamp to int8.
    function automatic exp_t model(input logic [31:0] dv, input logic [31:0] wv,
                                   input logic [7:0] b, input int n, input int sh);
        exp_t       e;
        longint     s = 0;
        logic [7:0] dd, ww;
        for (int i = 0; i < n; i++) begin
            dd = dv[8*i +: 8];
            ww = wv[8*i +: 8];
            s += longint'($signed(dd)) * longint'($signed(ww));
        end
        s += longint'($signed(b)) * (64'sd1 <<< sh);
        s = s >>> sh;
        if (s > 127) begin
            e.data = 8'h7F; e.ovf = 1'b1;
        end else if (s < -128) begin
            e.data = 8'h80; e.ovf = 1'b1;
        end else begin
            e.data = 8'(s); e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic mon(input int id, input logic ov, input logic ordy, input logic ird,
                       input logic ival, input logic [7:0] od, input logic oo);
        exp_t e;
        if (prev_ov[id] && prev_ordy[id])
            chk($sformatf("valid_drop%0d", id), ov, 1'b0);
        if (ov) begin
            chk($sformatf("in_ready_in_out%0d", id), ird, 1'b0);
            if (!prev_ov[id]) begin
                chk($sformatf("latency%0d", id), cyc, rise_exp[id]);
            end else if (!prev_ordy[id]) begin
                chk($sformatf("hold_data%0d", id), od, prev_od[id]);
                chk($sformatf("hold_ovf%0d", id), oo, prev_oo[id]);
            end
            if (ordy) begin
                if (exp_q[id].size() == 0) begin
                    chk($sformatf("spurious%0d", id), 1'b1, 1'b0);
                end else begin
                    e = exp_q[id].pop_front();
                    chk($sformatf("data%0d", id), od, e.data);
                    chk($sformatf("ovf%0d", id), oo, e.ovf);
                end
            end
        end
        if (ival && ird) begin
            xcnt[id]++;
            if (xcnt[id] == nin_of[id]) begin
                xcnt[id]     = 0;
                rise_exp[id] = cyc + 2;
            end
        end
        prev_ov[id]   = ov;
        prev_ordy[id] = ordy;
        prev_od[id]   = od;
        prev_oo[id]   = oo;
    endtask

    // Output-side monitor; a reset discards everything in flight.
    always @(negedge clk) begin
        if (reset) begin
            for (int id = 0; id < 3; id++) begin
                exp_q[id].delete();
                prev_ov[id]   = 1'b0;
                prev_ordy[id] = 1'b0;
                xcnt[id]      = 0;
                rise_exp[id]  = -1;
            end
        end else begin
            mon(0, out_valid_i, out_ready, in_ready_i, in_valid, out_data_i, out_ovf_i);
            mon(1, out_valid_f, out_ready, in_ready_f, in_valid, out_data_f, out_ovf_f);
            mon(2, out_valid1, out_ready1, in_ready1, in_valid1, out_data1, out_ovf1);
        end
    end

    // Downstream ready: normally 1, stalls 5 cycles per result in stress mode.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (or_block) begin
                out_ready = 1'b0;
            end else if (or_stall && out_valid_i && low_cnt < 5) begin
                out_ready = 1'b0;
                low_cnt++;
            end else begin
                out_ready = 1'b1;
                if (!out_valid_i) low_cnt = 0;
            end
        end
    end

    task automatic wait_accept();
        int t = 0;
        while (!in_ready_i && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("accept_timeout", in_ready_i, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_eval(input logic [31:0] dv, input logic [31:0] wv, input logic [7:0] b,
                            input bit gaps, input int npairs);
        exp_q[0].push_back(model(dv, wv, b, 4, 0));
        exp_q[1].push_back(model(dv, wv, b, 4, 4));
        for (int i = 0; i < npairs; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid  = 1'b0;
                    in_data   = 8'($urandom);
                    in_weight = 8'($urandom);
                    bias      = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            in_valid  = 1'b1;
            in_data   = dv[8*i +: 8];
            in_weight = wv[8*i +: 8];
            bias      = (i == 0) ? b : 8'($urandom);
            wait_accept();
        end
        in_valid  = 1'b0;
        in_data   = 8'($urandom);
        in_weight = 8'($urandom);
        bias      = 8'($urandom);
    endtask

    task automatic run_n1(input logic [7:0] d, input logic [7:0] w, input logic [7:0] b);
        int t = 0;
        exp_q[2].push_back(model({24'd0, d}, {24'd0, w}, b, 1, 0));
        in_valid1  = 1'b1;
        in_data1   = d;
        in_weight1 = w;
        bias1      = b;
        while (!in_ready1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("n1_accept_timeout", in_ready1, 1'b1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_data1  = 8'($urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    endtask

    initial begin
        int t;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        in_weight  = 8'd0;
        bias       = 8'd0;
        in_valid1  = 1'b0;
        in_data1   = 8'd0;
        in_weight1 = 8'd0;
        bias1      = 8'd0;
        out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_i, 1'b1);
        chk("rst_out_valid", out_valid_i, 1'b0);
        chk("rst_out_data", out_data_i, 8'd0);
        chk("rst_out_ovf", out_ovf_i, 1'b0);
        chk("rst_in_ready_n1", in_ready1, 1'b1);
        reset = 1'b0;

        // Directed cases: basic sum, saturation both ways, FXP scaling and floor.
        run_eval({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd2}}, 8'd5, 1'b0, 4);
        run_eval({4{8'd127}}, {4{8'd127}}, 8'd127, 1'b0, 4);
        run_eval({4{8'h80}}, {4{8'd127}}, 8'd0, 1'b0, 4);
        run_eval({24'd0, 8'h18}, {24'd0, 8'h20}, 8'h08, 1'b0, 4);
        run_eval({24'd0, 8'hFF}, {24'd0, 8'h01}, 8'h00, 1'b0, 4);
        wait_drain();

        // Handshake stress: random input gaps, output stalled 5 cycles each.
        or_stall = 1'b1;
        repeat (6) run_eval($urandom, $urandom, 8'($urandom), 1'b1, 4);
        wait_drain();
        or_stall = 1'b0;

        // Reset while a result is held in OUT.
        or_block = 1'b1;
        run_eval({4{8'd1}}, {4{8'd1}}, 8'd3, 1'b0, 4);
        t = 0;
        while (!out_valid_i && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("out_valid_reach", out_valid_i, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid_i, 1'b0);
        chk("async_rst_in_ready", in_ready_i, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        or_block = 1'b0;

        // Reset after 2 of 4 pairs, then a clean evaluation must give 4.
        run_eval({4{8'd9}}, {4{8'd9}}, 8'd50, 1'b0, 2);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid_i, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_eval({4{8'd1}}, {4{8'd1}}, 8'd0, 1'b0, 4);
        wait_drain();

        // NIN=1 corner cases.
        run_n1(8'd3, 8'hFD, 8'd2);
        run_n1(8'h80, 8'h80, 8'd0);
        run_n1(8'd5, 8'd5, 8'h9C);
        wait_drain();

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
